fetch_aligner: RTL and testbench

Instruction fetch realigner between the instruction memory port and the compressed-instruction decoder. It issues word-aligned fetch requests and buffers returned halfwords. It delivers one instruction per handshake, aligned to bit 0: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. It also handles pipeline redirects and fetch bus errors, and provides the PC of every delivered instruction.

---
 rtl/fetch_aligner_pkg.sv | 24 ++
 rtl/fetch_hwbuf.sv | 91 +++++++++
 rtl/fetch_aligner.sv | 189 ++++++++++++++++++
 tb/tb_fetch_aligner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_aligner_pkg.sv
// rtl/fetch_aligner_pkg.sv - shared constants and types for the fetch realigner
//
// Contents:
//   HW_W                halfword width in bits
//   HW_COMPRESSED_MASK  low bits of a halfword that mark a 32-bit instruction
//   fetch_state_t       fetch FSM state encoding (IDLE, REQ, DROP, FAULT)
//   hw_is_compressed()  true when a halfword starts a 16-bit instruction
package fetch_aligner_pkg;

    localparam int         HW_W               = 16;
    localparam logic [1:0] HW_COMPRESSED_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DROP  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    function automatic logic hw_is_compressed(input logic [HW_W-1:0] hw);
        return (hw[1:0] & HW_COMPRESSED_MASK) != HW_COMPRESSED_MASK;
    endfunction

endpackage

// File: rtl/fetch_hwbuf.sv
// rtl/fetch_hwbuf.sv - three-halfword shift buffer feeding the instruction realigner
//
// Ports:
//   clk, resetb   clock, asynchronous active-low reset
//   clear         drop all buffered halfwords (wins over enqueue/dequeue)
//   enq_num       halfwords appended this cycle (0..2); first one in enq_data[15:0]
//   enq_data      appended halfwords, lower address in [15:0]
//   deq_num       halfwords removed from the head this cycle (0..2)
//   hw0, hw1      head halfword and the one after it
//   count         halfwords currently held (0..3)
//   count_next    count after this cycle's clear/dequeue/enqueue
module fetch_hwbuf
    import fetch_aligner_pkg::*;
(
    input  logic            clk,
    input  logic            resetb,
    input  logic            clear,
    input  logic [1:0]      enq_num,
    input  logic [31:0]     enq_data,
    input  logic [1:0]      deq_num,
    output logic [HW_W-1:0] hw0,
    output logic [HW_W-1:0] hw1,
    output logic [1:0]      count,
    output logic [1:0]      count_next
);

    logic [47:0] store;
    logic [47:0] shifted;
    logic [47:0] merged;
    logic [1:0]  base;

    // Dequeue shifts the head out first; enqueued halfwords then land at
    // the first free slot of the shifted buffer. The fetch issue rule keeps
    // count_next at or below 3, so no slot is ever overrun.
    always_comb begin
        shifted = store;
        base    = count;
        case (deq_num)
            2'd1: begin
                shifted = {16'h0000, store[47:16]};
                base    = count - 2'd1;
            end
            2'd2: begin
                shifted = {32'h0000_0000, store[47:32]};
                base    = count - 2'd2;
            end
            default: ;
        endcase

        merged = shifted;
        if (enq_num != 2'd0) begin
            case (base)
                2'd0: begin
                    merged[15:0] = enq_data[15:0];
                    if (enq_num == 2'd2) begin
                        merged[31:16] = enq_data[31:16];
                    end
                end
                2'd1: begin
                    merged[31:16] = enq_data[15:0];
                    if (enq_num == 2'd2) begin
                        merged[47:32] = enq_data[31:16];
                    end
                end
                default: begin
                    merged[47:32] = enq_data[15:0];
                end
            endcase
        end

        count_next = base + enq_num;
        if (clear) begin
            merged     = '0;
            count_next = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            store <= '0;
            count <= 2'd0;
        end else begin
            store <= merged;
            count <= count_next;
        end
    end

    assign hw0 = store[15:0];
    assign hw1 = store[31:16];

endmodule

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - instruction fetch realigner between imem and the compressed decoder
//
// Ports:
//   clk, resetb      core clock, asynchronous active-low reset
//   imem_ready       fetch request outstanding (registered)
//   imem_addr        word-aligned fetch address (registered, held until response)
//   imem_valid       memory response for the outstanding request
//   imem_rresp       1 = OK, 0 = bus error
//   imem_rdata       fetched word, [15:0] is the lower-address halfword
//   redirect         flush and restart fetch at redirect_pc
//   redirect_pc      new PC, bit 0 ignored
//   ins_valid        ins_* fields valid
//   ins_ready        consumer accepts the instruction
//   ins_data         aligned instruction, [31:16] = 0 when compressed
//   ins_pc           address of ins_data
//   ins_compressed   ins_data is a 16-bit instruction
//   ins_fault        bus error at ins_pc, ins_data = 0
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetb,
    output logic        imem_ready,
    input  logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_rresp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic        ins_compressed,
    output logic        ins_fault
);

    fetch_state_t state;
    logic [31:0]  fpc;
    logic [31:0]  fpc_inc;
    logic [31:0]  buf_pc;
    logic         skip;
    logic         fault_done;

    logic [15:0]  hw0;
    logic [15:0]  hw1;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         buf_clear;
    logic [1:0]   enq_num;
    logic [31:0]  enq_data;
    logic [1:0]   deq_num;

    logic         head_comp;
    logic         comp_avail;
    logic         full_avail;
    logic         normal_valid;
    logic         fault_valid;
    logic         fire;
    logic         resp_ok;
    logic         issue_ok;
    logic         unused_bits;

    assign unused_bits = redirect_pc[0];

    fetch_hwbuf u_hwbuf (
        .clk        (clk),
        .resetb     (resetb),
        .clear      (buf_clear),
        .enq_num    (enq_num),
        .enq_data   (enq_data),
        .deq_num    (deq_num),
        .hw0        (hw0),
        .hw1        (hw1),
        .count      (count),
        .count_next (count_next)
    );

    assign head_comp    = hw_is_compressed(hw0);
    assign comp_avail   = (count != 2'd0) && head_comp;
    assign full_avail   = (count >= 2'd2) && !head_comp;
    assign normal_valid = comp_avail || full_avail;

    // The fault is only shown once every complete buffered instruction has
    // gone. A lone upper-half of a 32-bit instruction can never complete, so
    // it is reported as the faulting instruction at buf_pc. buf_pc always
    // equals the halfword-adjusted fault address once drained.
    assign fault_valid  = (state == ST_FAULT) && !fault_done && !normal_valid;

    assign ins_valid    = normal_valid || fault_valid;
    assign ins_pc       = buf_pc;
    assign ins_fault    = fault_valid;
    assign ins_compressed = comp_avail;

    always_comb begin
        ins_data = 32'h0000_0000;
        if (comp_avail) begin
            ins_data = {16'h0000, hw0};
        end else if (full_avail) begin
            ins_data = {hw1, hw0};
        end
    end

    // Redirect overrides both the consumer handshake and a same-cycle response.
    assign fire      = ins_valid && ins_ready && !redirect;
    assign resp_ok   = (state == ST_REQ) && imem_valid && imem_rresp && !redirect;
    assign buf_clear = redirect || (fire && fault_valid);
    assign deq_num   = (fire && normal_valid) ? (comp_avail ? 2'd1 : 2'd2) : 2'd0;
    assign enq_num   = resp_ok ? (skip ? 2'd1 : 2'd2) : 2'd0;
    assign enq_data  = skip ? {16'h0000, imem_rdata[31:16]} : imem_rdata;

    // A new word (up to two halfwords) must fit behind what will remain.
    assign issue_ok  = count_next <= 2'd1;
    assign fpc_inc   = {fpc[31:2] + 30'd1, 2'b00};

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_IDLE;
            imem_ready <= 1'b0;
            imem_addr  <= RESET_PC & ~32'd3;
            fpc        <= RESET_PC & ~32'd3;
            buf_pc     <= RESET_PC & ~32'd1;
            skip       <= RESET_PC[1];
            fault_done <= 1'b0;
        end else if (redirect) begin
            fpc        <= {redirect_pc[31:2], 2'b00};
            buf_pc     <= {redirect_pc[31:1], 1'b0};
            skip       <= redirect_pc[1];
            fault_done <= 1'b0;
            if ((state == ST_REQ || state == ST_DROP) && !imem_valid) begin
                // Old request still in flight: keep imem_addr stable and
                // throw its response away when it arrives.
                state <= ST_DROP;
            end else begin
                state      <= ST_REQ;
                imem_ready <= 1'b1;
                imem_addr  <= {redirect_pc[31:2], 2'b00};
            end
        end else begin
            if (fire && normal_valid) begin
                buf_pc <= buf_pc + (comp_avail ? 32'd2 : 32'd4);
            end
            if (fire && fault_valid) begin
                fault_done <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (issue_ok) begin
                        state      <= ST_REQ;
                        imem_ready <= 1'b1;
                        imem_addr  <= fpc;
                    end
                end
                ST_REQ: begin
                    if (imem_valid) begin
                        if (imem_rresp) begin
                            fpc  <= fpc_inc;
                            skip <= 1'b0;
                            if (issue_ok) begin
                                imem_addr <= fpc_inc;
                            end else begin
                                state      <= ST_IDLE;
                                imem_ready <= 1'b0;
                            end
                        end else begin
                            state      <= ST_FAULT;
                            imem_ready <= 1'b0;
                            fault_done <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    // Buffer is empty after the redirect, so issue right away.
                    if (imem_valid) begin
                        state     <= ST_REQ;
                        imem_addr <= fpc;
                    end
                end
                default: begin
                    imem_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - scoreboard bench for fetch_aligner
module tb_fetch_aligner;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        comp;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        resetb;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_rresp;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_compressed;
    logic        ins_fault;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [31:0] served[$];
    logic [31:0] mem[logic [31:0]];
    bit          err_map[logic [31:0]];
    bit          mem_en;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .resetb         (resetb),
        .imem_ready     (imem_ready),
        .imem_valid     (imem_valid),
        .imem_addr      (imem_addr),
        .imem_rresp     (imem_rresp),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .ins_compressed (ins_compressed),
        .ins_fault      (ins_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ins(input logic [31:0] d, input logic [31:0] pc, input logic c, input logic f);
        exp_t e;
        e.data  = d;
        e.pc    = pc;
        e.comp  = c;
        e.fault = f;
        exp_q.push_back(e);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    // Wait until the scoreboard is empty, then stop accepting so nothing
    // beyond the expected stream gets consumed.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        ins_ready = 1'b0;
    endtask

    // Memory model: answers any outstanding request one slot after it is seen.
    initial begin
        imem_valid = 1'b0;
        imem_rresp = 1'b1;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_valid) begin
                imem_valid = 1'b0;
            end else if (resetb && imem_ready && mem_en) begin
                imem_valid = 1'b1;
                imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 32'h0;
                imem_rresp = !err_map.exists(imem_addr);
                served.push_back(imem_addr);
            end
        end
    end

    // Monitor: every accepted instruction is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetb && ins_valid && ins_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ins: got data %h pc %h, expected nothing", ins_data, ins_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({ins_data, ins_pc, ins_compressed, ins_fault} !== {e.data, e.pc, e.comp, e.fault}) begin
                        errors++;
                        $display("FAIL ins_stream: got data %h pc %h c %b f %b expected data %h pc %h c %b f %b",
                                 ins_data, ins_pc, ins_compressed, ins_fault, e.data, e.pc, e.comp, e.fault);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ins_ready   = 1'b1;
        mem_en      = 1'b1;

        mem[32'h0000_0000] = 32'h00A0_0093;
        mem[32'h0000_0040] = 32'h4501_4505;
        mem[32'h0000_0080] = 32'h0093_4505;
        mem[32'h0000_0084] = 32'h0000_0A00;
        mem[32'h0000_0100] = 32'hFFFF_FFFF;
        mem[32'h0000_0104] = 32'h4509_FFFF;
        mem[32'h0000_001C] = 32'h4501_4505;
        err_map[32'h0000_0020] = 1'b1;
        mem[32'h0000_0200] = 32'h00A0_0093;
        mem[32'h0000_0204] = 32'h4501_4505;
        mem[32'h0000_0208] = 32'h0000_0013;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_ready", 32'(imem_ready), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_ins_data", ins_data, 32'h0);
        check("rst_ins_pc", ins_pc, 32'h0);
        check("rst_ins_compressed", 32'(ins_compressed), 32'd0);
        check("rst_ins_fault", 32'(ins_fault), 32'd0);

        // Basic 32-bit fetch at RESET_PC
        expect_ins(32'h00A0_0093, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        resetb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("first_req_ready", 32'(imem_ready), 32'd1);
        check("first_req_addr", imem_addr, 32'h0);
        drain("drain_basic");

        // Two compressed instructions in one word
        expect_ins(32'h0000_4505, 32'h40, 1'b1, 1'b0);
        expect_ins(32'h0000_4501, 32'h42, 1'b1, 1'b0);
        do_redirect(32'h40);
        ins_ready = 1'b1;
        drain("drain_two_c");
        repeat (6) step();
        check("next_fetch_addr", imem_addr, 32'h44);

        // 32-bit instruction straddling a word boundary
        expect_ins(32'h0000_4505, 32'h80, 1'b1, 1'b0);
        expect_ins(32'h0A00_0093, 32'h82, 1'b0, 1'b0);
        do_redirect(32'h80);
        ins_ready = 1'b1;
        drain("drain_straddle");

        // Redirect while a request is outstanding
        mem_en = 1'b0;
        repeat (4) step();
        served.delete();
        do_redirect(32'h100);
        repeat (3) step();
        check("outstanding_ready", 32'(imem_ready), 32'd1);
        check("outstanding_addr", imem_addr, 32'h100);
        do_redirect(32'h106);
        @(negedge clk);
        check("redirect_ins_valid", 32'(ins_valid), 32'd0);
        check("drop_addr_held", imem_addr, 32'h100);
        expect_ins(32'h0000_4509, 32'h106, 1'b1, 1'b0);
        step();
        mem_en    = 1'b1;
        ins_ready = 1'b1;
        drain("drain_redirect");
        check("served_dropped", served.size() > 0 ? served[0] : 32'hDEAD_BEEF, 32'h100);
        check("served_refetch", served.size() > 1 ? served[1] : 32'hDEAD_BEEF, 32'h104);

        // Bus error after a buffered instruction
        expect_ins(32'h0000_4505, 32'h1C, 1'b1, 1'b0);
        expect_ins(32'h0000_4501, 32'h1E, 1'b1, 1'b0);
        expect_ins(32'h0000_0000, 32'h20, 1'b0, 1'b1);
        do_redirect(32'h1C);
        ins_ready = 1'b1;
        drain("drain_fault");
        served.delete();
        repeat (10) step();
        check("fault_no_request", 32'(imem_ready), 32'd0);
        check("fault_no_served", 32'(served.size()), 32'd0);
        check("fault_ins_valid", 32'(ins_valid), 32'd0);

        // Backpressure: outputs stable, no overfetch
        do_redirect(32'h200);
        begin
            int n;
            n = 0;
            while (!ins_valid && n < 50) begin
                step();
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(ins_valid), 32'd1);
            check("stall_data", ins_data, 32'h00A0_0093);
            check("stall_pc", ins_pc, 32'h200);
        end
        repeat (4) step();
        check("stall_no_overfetch", 32'(served.size()), 32'd1);
        expect_ins(32'h00A0_0093, 32'h200, 1'b0, 1'b0);
        expect_ins(32'h0000_4505, 32'h204, 1'b1, 1'b0);
        expect_ins(32'h0000_4501, 32'h206, 1'b1, 1'b0);
        expect_ins(32'h0000_0013, 32'h208, 1'b0, 1'b0);
        step();
        ins_ready = 1'b1;
        drain("drain_stall");
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
